// File: rtl/datapath_ctrl_pkg.sv
// rtl/datapath_ctrl_pkg.sv - shared constants and types for the datapath controller
//
// Contents:
//   OPC_*            RV32I major opcodes handled by the controller
//   F7_BASE/F7_ALT   funct7 values that select the base / alternate operation
//   alu_op_e         3-bit ALU operation code driven on ALUOp
//   state_e          controller FSM states
//   funct3_alu_op    funct3 to ALU operation for the register/immediate ALU group

package datapath_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // funct3 = 011 (SLTU/SLTIU) has no ALU code; callers treat it as illegal,
  // so the ADD returned for it is never used.
  function automatic alu_op_e funct3_alu_op(input logic [2:0] funct3);
    alu_op_e op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational opcode/funct to ALU operation and legality decode
//
// Ports:
//   opcode  in   7  instruction[6:0]
//   funct3  in   3  instruction[14:12]
//   funct7  in   7  instruction[31:25]
//   alu_op  out  3  ALU operation (ADD when illegal)
//   legal   out  1  instruction is supported by the controller

module alu_op_decode
  import datapath_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_e    alu_op,
  output logic       legal
);

  logic is_shift;
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b0;
    case (opcode)
      OPC_OP: begin
        // The alternate funct7 only exists as SUB here; SRA is not supported.
        if (funct7 == F7_BASE && funct3 != 3'b011) begin
          legal  = 1'b1;
          alu_op = funct3_alu_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          legal  = 1'b1;
          alu_op = ALU_SUB;
        end
      end
      OPC_OPIMM: begin
        // Upper immediate bits are only constrained for shifts (SRAI rejected).
        if (funct3 != 3'b011 && (!is_shift || funct7 == F7_BASE)) begin
          legal  = 1'b1;
          alu_op = funct3_alu_op(funct3);
        end
      end
      OPC_LOAD, OPC_STORE: begin
        legal  = 1'b1;
        alu_op = ALU_ADD;
      end
      OPC_BRANCH: begin
        // BEQ (000) and BNE (001) only.
        if (funct3[2:1] == 2'b00) begin
          legal  = 1'b1;
          alu_op = ALU_SUB;
        end
      end
      default: begin
        legal  = 1'b0;
        alu_op = ALU_ADD;
      end
    endcase
  end

endmodule

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - multicycle control FSM sequencing the datapath for RV32I subset
//
// Ports:
//   clk             in   1     system clock
//   reset           in   1     asynchronous active-low reset
//   instr_valid     in   1     instruction offered
//   instr_ready     out  1     controller idle, can accept an instruction
//   instr_in        in   XLEN  offered instruction
//   ZeroFlag        in   1     ALU zero flag from the datapath
//   instruction     out  XLEN  latched instruction for the immediate path
//   reg1_addr       out  5     rs1
//   reg2_addr       out  5     rs2
//   write_reg_addr  out  5     rd
//   ctrl0           out  1     register-file write enable
//   ctrl1           out  1     ALU-result path enable
//   ctrl2           out  1     ALU operand B from immediate
//   ctrl3           out  1     memory read / memory-to-register select
//   ctrl4           out  1     memory write enable
//   ALUOp           out  3     ALU operation code
//   done            out  1     pulse on the last cycle of an instruction
//   illegal         out  1     pulse in DECODE for an unsupported instruction
//   branch_taken    out  1     branch outcome, valid with done for BRANCH

module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int MEM_CYCLES = 1,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [XLEN-1:0] instr_in,
  input  logic            ZeroFlag,
  output logic [XLEN-1:0] instruction,
  output logic [4:0]      reg1_addr,
  output logic [4:0]      reg2_addr,
  output logic [4:0]      write_reg_addr,
  output logic            ctrl0,
  output logic            ctrl1,
  output logic            ctrl2,
  output logic            ctrl3,
  output logic            ctrl4,
  output logic [2:0]      ALUOp,
  output logic            done,
  output logic            illegal,
  output logic            branch_taken
);

  localparam logic [3:0] MEM_LAST = 4'(MEM_CYCLES - 1);

  state_e     state;
  state_e     state_d;
  logic [3:0] mem_cnt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  alu_op_e    dec_alu_op;
  logic       dec_legal;

  logic is_op, is_opimm, is_load, is_store, is_branch;
  logic mem_last;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  assign is_op     = (opcode == OPC_OP);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);

  assign mem_last = (mem_cnt == 4'd0);

  alu_op_decode u_alu_op_decode (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  // Field outputs follow the latched word, so they are valid from DECODE on
  // and stay put until the next handshake; reset clears the word to 0, which
  // decodes as illegal and therefore yields ALUOp = ADD.
  assign reg1_addr      = instruction[19:15];
  assign reg2_addr      = instruction[24:20];
  assign write_reg_addr = instruction[11:7];
  assign ALUOp          = dec_alu_op;

  assign instr_ready = (state == ST_IDLE);
  assign illegal     = (state == ST_DECODE) && !dec_legal;

  // EXEC is only entered for legal instructions, so a BRANCH there is BEQ/BNE
  // and funct3[0] alone separates them.
  assign branch_taken = (state == ST_EXEC) && is_branch && (funct3[0] ? !ZeroFlag : ZeroFlag);

  assign done = (state == ST_WB)
             || ((state == ST_EXEC) && is_branch)
             || ((state == ST_MEM) && is_store && mem_last);

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (instr_valid) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = dec_legal ? ST_EXEC : ST_IDLE;
      end
      ST_EXEC: begin
        if (is_op || is_opimm)       state_d = ST_WB;
        else if (is_load || is_store) state_d = ST_MEM;
        else                          state_d = ST_IDLE;
      end
      ST_MEM: begin
        if (mem_last) state_d = is_load ? ST_WB : ST_IDLE;
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so they switch exactly on the
  // clock edge that enters the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      instruction <= '0;
      mem_cnt     <= 4'd0;
      ctrl0       <= 1'b0;
      ctrl1       <= 1'b0;
      ctrl2       <= 1'b0;
      ctrl3       <= 1'b0;
      ctrl4       <= 1'b0;
    end else begin
      state <= state_d;

      if (state == ST_IDLE && instr_valid) begin
        instruction <= instr_in;
      end

      if (state == ST_EXEC) begin
        mem_cnt <= MEM_LAST;
      end else if (state == ST_MEM && !mem_last) begin
        mem_cnt <= mem_cnt - 4'd1;
      end

      ctrl0 <= (state_d == ST_WB) && (instruction[11:7] != 5'd0);
      ctrl1 <= (state_d == ST_EXEC) && (is_op || is_opimm || is_store);
      ctrl2 <= ((state_d == ST_EXEC) && (is_opimm || is_load || is_store))
            || (state_d == ST_MEM);
      ctrl3 <= ((state_d == ST_MEM) || (state_d == ST_WB)) && is_load;
      ctrl4 <= (state_d == ST_MEM) && is_store;
    end
  end

endmodule
